// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
//  Shared types for the cache tag store.
//   - TAG_BITS          : tag width that tag_entry_t is built for
//   - tag_entry_t       : one way's stored status and tag {valid, dirty, tag}
//   - tag_array_state_t : IDLE (array usable) / SWEEP (hardware invalidate)
//   - tag_parity()      : even-parity bit over a whole entry
//  Optional feature macro: TAG_ARRAY_PARITY_EN (uses tag_parity()).
// -----------------------------------------------------------------------------
package cache_pkg;

    localparam int TAG_BITS = 20;

    typedef struct packed {
        logic                valid;
        logic                dirty;
        logic [TAG_BITS-1:0] tag;
    } tag_entry_t;

    typedef enum logic {
        IDLE,
        SWEEP
    } tag_array_state_t;

    // Stored bit makes the total number of ones over {entry, parity} even.
    function automatic logic tag_parity(input tag_entry_t e);
        return ^e;
    endfunction

endpackage

// File: rtl/tag_way_bank.sv
// -----------------------------------------------------------------------------
// tag_way_bank
//  Storage for one way: DEPTH x tag_entry_t, one write port, two independent
//  registered read ports. Read data holds while the port's enable is low.
//  Ports:
//   clk_i, rst_i   clock, synchronous active-high reset (read registers only)
//   we_i           write enable for this way
//   waddr_i        write set index
//   wdata_i        entry to store
//   re_i[p]        read enable, port p
//   raddr_i[p]     read set index, port p
//   rpar_o[p]      stored parity bit read with rdata_o (TAG_ARRAY_PARITY_EN)
//   rdata_o[p]     registered read data, port p
//  Optional feature macro: TAG_ARRAY_PARITY_EN.
// -----------------------------------------------------------------------------
module tag_way_bank
    import cache_pkg::*;
#(
    parameter int INDEX_WIDTH = 6
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        we_i,
    input  logic [INDEX_WIDTH-1:0]      waddr_i,
    input  tag_entry_t                  wdata_i,
    input  logic [1:0]                  re_i,
    input  logic [1:0][INDEX_WIDTH-1:0] raddr_i,
`ifdef TAG_ARRAY_PARITY_EN
    output logic [1:0]                  rpar_o,
`endif
    output tag_entry_t [1:0]            rdata_o
);

    localparam int DEPTH = 2**INDEX_WIDTH;

    tag_entry_t mem [DEPTH];

    // NOTE: the storage array is deliberately not reset; clearing a RAM in one
    // cycle is not possible, which is why the top sweeps it set by set.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

`ifdef TAG_ARRAY_PARITY_EN
    logic par_mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            par_mem[waddr_i] <= tag_parity(wdata_i);
        end
    end
`endif

    // NOTE: sequential state is always assigned with <=, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_o <= '0;
`ifdef TAG_ARRAY_PARITY_EN
            rpar_o  <= '0;
`endif
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (re_i[p]) begin
                    rdata_o[p] <= mem[raddr_i[p]];
`ifdef TAG_ARRAY_PARITY_EN
                    rpar_o[p]  <= par_mem[raddr_i[p]];
`endif
                end
            end
        end
    end

endmodule

// File: rtl/tag_array.sv
// -----------------------------------------------------------------------------
// tag_array
//  N-way cache tag store: per-way {tag, valid, dirty}, one write port, two
//  read ports (lookup and refill/writeback). On reset or flush a hardware
//  sweep invalidates every set, one set per cycle, before ready_o rises.
//  Reads are write-first: a write to the index being read is forwarded for
//  the written ways; unwritten ways return stored data.
//  Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   flush_i          start invalidate sweep (honoured in IDLE only)
//   ready_o          1 = array usable, 0 while sweeping
//   write_i          write strobe
//   write_way_i      per-way write enable
//   write_index_i    write set index
//   write_tag_i      tag to store
//   write_valid_i    valid bit to store
//   write_dirty_i    dirty bit to store
//   read_i[p]        read strobe, port p
//   read_index_i[p]  read set index, port p
//   read_tag_o[p][w] tag of way w, port p (1-cycle latency, holds when idle)
//   read_valid_o     valid bits, same timing
//   read_dirty_o     dirty bits, same timing
//   parity_error_o   parity mismatch per port/way (TAG_ARRAY_PARITY_EN only)
//  Optional feature macro: TAG_ARRAY_PARITY_EN.
// -----------------------------------------------------------------------------
module tag_array
    import cache_pkg::*;
#(
    parameter int INDEX_WIDTH = 6,
    parameter int TAG_SIZE    = TAG_BITS,
    parameter int WAYS        = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 flush_i,
    output logic                                 ready_o,
    input  logic                                 write_i,
    input  logic [WAYS-1:0]                      write_way_i,
    input  logic [INDEX_WIDTH-1:0]               write_index_i,
    input  logic [TAG_SIZE-1:0]                  write_tag_i,
    input  logic                                 write_valid_i,
    input  logic                                 write_dirty_i,
    input  logic [1:0]                           read_i,
    input  logic [1:0][INDEX_WIDTH-1:0]          read_index_i,
    output logic [1:0][WAYS-1:0][TAG_SIZE-1:0]   read_tag_o,
    output logic [1:0][WAYS-1:0]                 read_valid_o,
`ifdef TAG_ARRAY_PARITY_EN
    output logic [1:0][WAYS-1:0]                 parity_error_o,
`endif
    output logic [1:0][WAYS-1:0]                 read_dirty_o
);

    // tag_entry_t has a fixed tag width, so the parameter must agree with it.
    if (TAG_SIZE != TAG_BITS) begin : g_bad_tag_size
        $error("tag_array: TAG_SIZE must equal cache_pkg::TAG_BITS");
    end

    tag_array_state_t          state;
    logic [INDEX_WIDTH-1:0]    sweep_cnt;
    logic                      ready_q;

    logic                      sweeping;
    logic                      user_en;
    tag_entry_t                wr_entry;
    logic [WAYS-1:0]           bank_we;
    logic [INDEX_WIDTH-1:0]    bank_waddr;
    tag_entry_t                bank_wdata;
    logic [1:0]                rd_en;

    tag_entry_t [WAYS-1:0][1:0] bank_rdata;
`ifdef TAG_ARRAY_PARITY_EN
    logic [WAYS-1:0][1:0]       bank_rpar;
`endif

    // Per-port forwarding capture, updated only when that port reads so the
    // outputs hold with the rest of the read data.
    logic [1:0][WAYS-1:0]      fwd_hit_q;
    tag_entry_t [1:0]          fwd_data_q;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= SWEEP;
            sweep_cnt <= '0;
            ready_q   <= 1'b0;
        end else begin
            case (state)
                SWEEP: begin
                    sweep_cnt <= sweep_cnt + 1'b1;
                    if (sweep_cnt == '1) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                IDLE: begin
                    if (flush_i) begin
                        state     <= SWEEP;
                        sweep_cnt <= '0;
                        ready_q   <= 1'b0;
                    end
                end
                default: state <= SWEEP;
            endcase
        end
    end

    assign ready_o = ready_q;

    // ---------------------------------------------------------- write mux
    // NOTE: every always_comb output gets a default before any branch, so no
    // path can leave a signal unassigned and infer a latch.
    always_comb begin
        sweeping   = (state == SWEEP);
        // A flush cycle drops the user's concurrent write and read.
        user_en    = (state == IDLE) && !flush_i && !rst_i;
        wr_entry   = '{valid: write_valid_i, dirty: write_dirty_i, tag: write_tag_i};
        bank_we    = '0;
        bank_waddr = write_index_i;
        bank_wdata = wr_entry;
        rd_en      = user_en ? read_i : 2'b00;
        if (sweeping) begin
            bank_we    = '1;
            bank_waddr = sweep_cnt;
            bank_wdata = '0;
        end else if (user_en && write_i) begin
            bank_we    = write_way_i;
        end
    end

    // ------------------------------------------------------------- banks
    for (genvar w = 0; w < WAYS; w++) begin : g_way
        tag_way_bank #(
            .INDEX_WIDTH (INDEX_WIDTH)
        ) u_bank (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .we_i    (bank_we[w]),
            .waddr_i (bank_waddr),
            .wdata_i (bank_wdata),
            .re_i    (rd_en),
            .raddr_i (read_index_i),
`ifdef TAG_ARRAY_PARITY_EN
            .rpar_o  (bank_rpar[w]),
`endif
            .rdata_o (bank_rdata[w])
        );
    end

    // ------------------------------------------------- collision capture
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fwd_hit_q  <= '0;
            fwd_data_q <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (rd_en[p]) begin
                    fwd_hit_q[p]  <= (write_i && (read_index_i[p] == write_index_i))
                                     ? write_way_i : '0;
                    fwd_data_q[p] <= wr_entry;
                end
            end
        end
    end

    // ----------------------------------------------------------- outputs
    always_comb begin
        tag_entry_t sel;
        sel          = '0;
        read_tag_o   = '0;
        read_valid_o = '0;
        read_dirty_o = '0;
`ifdef TAG_ARRAY_PARITY_EN
        parity_error_o = '0;
`endif
        for (int p = 0; p < 2; p++) begin
            for (int w = 0; w < WAYS; w++) begin
                sel = fwd_hit_q[p][w] ? fwd_data_q[p] : bank_rdata[w][p];
                read_tag_o[p][w]   = sel.tag;
                read_valid_o[p][w] = sel.valid;
                read_dirty_o[p][w] = sel.dirty;
`ifdef TAG_ARRAY_PARITY_EN
                // Forwarded data never touched storage, so it cannot be corrupt.
                parity_error_o[p][w] = !fwd_hit_q[p][w] &&
                    (tag_parity(bank_rdata[w][p]) != bank_rpar[w][p]);
`endif
            end
        end
    end

endmodule

// File: tb/tb_tag_array.sv
// -----------------------------------------------------------------------------
// tb_tag_array
//  Directed self-checking bench for tag_array (INDEX_WIDTH=6, TAG_SIZE=20,
//  WAYS=4). Covers reset sweep length, invalidated contents, write/read,
//  hold, multi-way writes, no-op writes, write-first forwarding, flush with
//  dropped accesses, ignored flush mid-sweep, reset mid-sweep and, with
//  TAG_ARRAY_PARITY_EN, parity error detection.
// -----------------------------------------------------------------------------
module tb_tag_array;

    localparam int IW = 6;
    localparam int TS = 20;
    localparam int NW = 4;

    logic                        clk_i = 1'b0;
    logic                        rst_i;
    logic                        flush_i;
    logic                        ready_o;
    logic                        write_i;
    logic [NW-1:0]               write_way_i;
    logic [IW-1:0]               write_index_i;
    logic [TS-1:0]               write_tag_i;
    logic                        write_valid_i;
    logic                        write_dirty_i;
    logic [1:0]                  read_i;
    logic [1:0][IW-1:0]          read_index_i;
    logic [1:0][NW-1:0][TS-1:0]  read_tag_o;
    logic [1:0][NW-1:0]          read_valid_o;
    logic [1:0][NW-1:0]          read_dirty_o;
`ifdef TAG_ARRAY_PARITY_EN
    logic [1:0][NW-1:0]          parity_error_o;
`endif

    int tests  = 0;
    int failed = 0;

    always #5 clk_i = ~clk_i;

    tag_array #(
        .INDEX_WIDTH (IW),
        .TAG_SIZE    (TS),
        .WAYS        (NW)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .ready_o        (ready_o),
        .write_i        (write_i),
        .write_way_i    (write_way_i),
        .write_index_i  (write_index_i),
        .write_tag_i    (write_tag_i),
        .write_valid_i  (write_valid_i),
        .write_dirty_i  (write_dirty_i),
        .read_i         (read_i),
        .read_index_i   (read_index_i),
        .read_tag_o     (read_tag_o),
        .read_valid_o   (read_valid_o),
`ifdef TAG_ARRAY_PARITY_EN
        .parity_error_o (parity_error_o),
`endif
        .read_dirty_o   (read_dirty_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [IW-1:0] idx, input logic [NW-1:0] way,
                      input logic [TS-1:0] tag, input logic v, input logic d);
        write_i       = 1'b1;
        write_index_i = idx;
        write_way_i   = way;
        write_tag_i   = tag;
        write_valid_i = v;
        write_dirty_i = d;
        tick();
        write_i       = 1'b0;
    endtask

    task automatic rd(input logic [1:0] en, input logic [IW-1:0] i0, input logic [IW-1:0] i1);
        read_i          = en;
        read_index_i[0] = i0;
        read_index_i[1] = i1;
        tick();
        read_i          = 2'b00;
    endtask

    // Ticks until ready_o rises, bounded; returns the number of edges taken.
    task automatic wait_ready(output int n);
        n = 0;
        while (!ready_o && n < 200) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int          n;
        logic [NW-1:0] any_valid;
        logic [NW-1:0] any_dirty;

        rst_i = 1'b1; flush_i = 1'b0; write_i = 1'b0; write_way_i = '0;
        write_index_i = '0; write_tag_i = '0; write_valid_i = 1'b0;
        write_dirty_i = 1'b0; read_i = 2'b00; read_index_i = '0;

        // ---- 1. reset, sweep length, everything invalid
        tick();
        check("rst_ready", ready_o, 0);
        check("rst_valid", read_valid_o, 0);
        check("rst_tag",   read_tag_o, 0);
        rst_i = 1'b0;
        wait_ready(n);
        check("reset_sweep_len", n, 64);

        any_valid = '0;
        any_dirty = '0;
        for (int i = 0; i < 64; i++) begin
            rd(2'b11, IW'(i), IW'(63 - i));
            any_valid |= read_valid_o[0] | read_valid_o[1];
            any_dirty |= read_dirty_o[0] | read_dirty_o[1];
        end
        check("swept_valid", any_valid, 0);
        check("swept_dirty", any_dirty, 0);

        // ---- 2. write idx5 way2, read back on port 0
        wr(6'd5, 4'b0100, 20'hABCDE, 1'b1, 1'b1);
        rd(2'b01, 6'd5, 6'd0);
        check("w5_tag2",   read_tag_o[0][2], 20'hABCDE);
        check("w5_valid",  read_valid_o[0], 4'b0100);
        check("w5_dirty",  read_dirty_o[0], 4'b0100);

        // hold while read_i=0, even with a new index presented
        read_index_i[0] = 6'd7;
        tick();
        check("hold_tag2", read_tag_o[0][2], 20'hABCDE);

        // write_i with no way enabled changes nothing
        wr(6'd5, 4'b0000, 20'h00000, 1'b0, 1'b0);
        rd(2'b01, 6'd5, 6'd0);
        check("noop_tag2",  read_tag_o[0][2], 20'hABCDE);
        check("noop_valid", read_valid_o[0], 4'b0100);

        // multi-way write, read on port 1
        wr(6'd7, 4'b1010, 20'h5A5A5, 1'b1, 1'b0);
        rd(2'b10, 6'd0, 6'd7);
        check("multi_valid", read_valid_o[1], 4'b1010);
        check("multi_tag3",  read_tag_o[1][3], 20'h5A5A5);
        check("multi_dirty", read_dirty_o[1], 4'b0000);

        // ---- 3. collision: write-first forwarding on port 1
        wr(6'd9, 4'b0010, 20'h22222, 1'b1, 1'b1);
        write_i = 1'b1; write_index_i = 6'd9; write_way_i = 4'b0001;
        write_tag_i = 20'h11111; write_valid_i = 1'b1; write_dirty_i = 1'b0;
        read_i = 2'b10; read_index_i[1] = 6'd9;
        tick();
        write_i = 1'b0; read_i = 2'b00;
        check("fwd_tag0",   read_tag_o[1][0], 20'h11111);
        check("fwd_tag1",   read_tag_o[1][1], 20'h22222);
        check("fwd_valid",  read_valid_o[1], 4'b0011);
        check("fwd_dirty",  read_dirty_o[1], 4'b0010);
        check("port0_indep", read_valid_o[0], 4'b0100);

        // ---- 4. fill, flush with dropped accesses, write during sweep
        for (int i = 0; i < 4; i++) wr(IW'(i), 4'b1111, TS'(i + 1), 1'b1, 1'b0);
        flush_i = 1'b1;
        write_i = 1'b1; write_index_i = 6'd4; write_way_i = 4'b1111;
        write_tag_i = 20'hFFFFF; write_valid_i = 1'b1; write_dirty_i = 1'b1;
        read_i = 2'b01; read_index_i[0] = 6'd0;
        tick();
        flush_i = 1'b0; write_i = 1'b0; read_i = 2'b00;
        check("flush_ready", ready_o, 0);
        check("flush_rd_drop", read_valid_o[0], 4'b0100);

        n = 0;
        while (!ready_o && n < 200) begin
            if (n == 9) begin
                write_i = 1'b1; write_index_i = 6'd2; write_way_i = 4'b1111;
                write_tag_i = 20'h77777; write_valid_i = 1'b1;
                read_i = 2'b01; read_index_i[0] = 6'd1;
            end else if (n == 19) begin
                flush_i = 1'b1;
            end
            tick();
            n++;
            write_i = 1'b0; read_i = 2'b00; flush_i = 1'b0;
        end
        check("flush_sweep_len", n, 64);
        check("sweep_rd_hold", read_valid_o[0], 4'b0100);

        any_valid = '0;
        for (int i = 0; i < 6; i++) begin
            rd(2'b01, IW'(i), 6'd0);
            any_valid |= read_valid_o[0];
        end
        check("flushed_valid", any_valid, 0);

        // ---- 5. reset mid-sweep restarts the count
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        check("mid_ready", ready_o, 0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("rerst_valid", read_valid_o, 0);
        wait_ready(n);
        check("rerst_sweep_len", n, 64);

`ifdef TAG_ARRAY_PARITY_EN
        // ---- 6. corrupt a stored bit, parity error on that way only
        wr(6'd3, 4'b0010, 20'h12345, 1'b1, 1'b0);
        dut.g_way[1].u_bank.mem[3] = dut.g_way[1].u_bank.mem[3] ^ 22'h1;
        rd(2'b11, 6'd3, 6'd4);
        check("par_err_p0", parity_error_o[0], 4'b0010);
        check("par_err_p1", parity_error_o[1], 4'b0000);
        check("par_tag",    read_tag_o[0][1], 20'h12344);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
